// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: PCSrc encodings,
// fixed fetch vectors and the pipeline bubble instruction.
package cpu_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ  = 3'b000,
        PCSRC_BR   = 3'b001,
        PCSRC_J    = 3'b010,
        PCSRC_JR   = 3'b011,
        PCSRC_IRQ  = 3'b100,
        PCSRC_EXC  = 3'b101,
        PCSRC_JALR = 3'b110
    } pcsrc_e;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
    localparam logic [31:0] XADR_PC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // J-type target: upper nibble of PC+4, 26-bit index, word aligned.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// External interrupt synchroniser, rising-edge detector and pending latch.
// IF_IRQ_SYNC_EN: two-flop synchroniser ahead of the edge detector;
// otherwise irq_in is assumed synchronous and is registered once.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic accept,
    output logic pending
);

    logic lvl;
    logic lvl_d;
    logic rise;

`ifdef IF_IRQ_SYNC_EN
    logic meta;

    // Two-flop synchroniser for the asynchronous request level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            lvl  <= 1'b0;
        end else begin
            meta <= irq_in;
            lvl  <= meta;
        end
    end
`else
    // Single capture register for a clk-synchronous request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl <= 1'b0;
        end else begin
            lvl <= irq_in;
        end
    end
`endif

    // Rising edge of the synchronised level.
    always_comb begin
        rise = lvl & ~lvl_d;
    end

    // Edge history and pending latch; a fresh edge beats acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            lvl_d   <= lvl;
            pending <= rise | (pending & ~accept);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Selects next PC from EX branch resolution, stall and ID-stage PCSrc,
// and presents the kernel-masked pending interrupt to Control.
// IF_IRQ_SYNC_EN selects the two-flop interrupt synchroniser.
module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] ILLOP_PC = cpu_pkg::ILLOP_PC,
    parameter logic [31:0] XADR_PC  = cpu_pkg::XADR_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        irq_in,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        irq_to_id
);

    import cpu_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq_pending;
    logic        irq_accept;

    // PC+4 keeps the kernel-mode bit; redirect decode from the ID instruction.
    always_comb begin
        pc_plus4    = {pc[31], pc[30:0] + 31'd4};
        redirect    = 1'b0;
        redirect_pc = pc_plus4;
        if (id_valid) begin
            case (pc_src)
                PCSRC_J: begin
                    redirect    = 1'b1;
                    redirect_pc = jump_target(id_pc_plus4, id_instr);
                end
                PCSRC_JR, PCSRC_JALR: begin
                    redirect    = 1'b1;
                    redirect_pc = jr_target;
                end
                PCSRC_IRQ: begin
                    redirect    = 1'b1;
                    redirect_pc = ILLOP_PC;
                end
                PCSRC_EXC: begin
                    redirect    = 1'b1;
                    redirect_pc = XADR_PC;
                end
                default: begin
                    redirect    = 1'b0;
                    redirect_pc = pc_plus4;
                end
            endcase
        end
    end

    // Interrupt visible only for a valid user-mode instruction in ID.
    always_comb begin
        irq_to_id  = irq_pending & id_valid & ~id_pc_plus4[31];
        irq_accept = irq_to_id & (pc_src == PCSRC_IRQ) & ~stall & ~branch_taken;
    end

    assign instr_addr = pc;

    // PC and IF/ID register: branch > stall > ID redirect > sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= RESET_PC;
            id_valid    <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_target;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= branch_target;
            id_valid    <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
            id_instr    <= id_instr;
            id_pc_plus4 <= id_pc_plus4;
            id_valid    <= id_valid;
        end else if (redirect) begin
            pc          <= redirect_pc;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= redirect_pc;
            id_valid    <= 1'b0;
        end else begin
            pc          <= pc_plus4;
            id_instr    <= instr_data;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end
    end

    irq_sync u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .accept  (irq_accept),
        .pending (irq_pending)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        irq_in;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        irq_to_id;

    int total;
    int bad;

`ifdef IF_IRQ_SYNC_EN
    localparam int IRQ_LAT = 3;
`else
    localparam int IRQ_LAT = 2;
`endif

    if_stage #(
        .RESET_PC (32'h8000_0000),
        .ILLOP_PC (32'h8000_0004),
        .XADR_PC  (32'h8000_0008)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_src        (pc_src),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .irq_in        (irq_in),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_valid      (id_valid),
        .irq_to_id     (irq_to_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; pc_src = 3'b000; jr_target = '0;
        branch_taken = 1'b0; branch_target = '0; irq_in = 1'b0;
        instr_data = 32'h2008_0001;
        step(); step();
        total++; if (instr_addr !== 32'h8000_0000) begin bad++; $display("FAIL reset_addr got=%h exp=80000000", instr_addr); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
        total++; if (id_pc_plus4 !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc4 got=%h exp=80000000", id_pc_plus4); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_to_id); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp = 32'h8000_0000 + 32'(4 * i);
            total++; if (instr_addr !== exp) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, instr_addr, exp); end
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, id_valid); end
            total++; if (id_pc_plus4 !== exp) begin bad++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, id_pc_plus4, exp); end
            total++; if (id_instr !== 32'h2008_0001) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=20080001", i, id_instr); end
        end
    endtask

    task automatic test_jump();
        instr_data = 32'h0800_0010;
        step();
        total++; if (id_instr !== 32'h0800_0010) begin bad++; $display("FAIL j_fetch got=%h exp=08000010", id_instr); end
        pc_src = 3'b010;
        instr_data = 32'h2008_0001;
        step();
        total++; if (instr_addr !== 32'h8000_0040) begin bad++; $display("FAIL j_addr got=%h exp=80000040", instr_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL j_bubble_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL j_bubble_instr got=%h exp=0", id_instr); end
        total++; if (id_pc_plus4 !== 32'h8000_0040) begin bad++; $display("FAIL j_bubble_pc4 got=%h exp=80000040", id_pc_plus4); end
        // pc_src still 010 but ID holds a bubble: must fetch sequentially
        step();
        total++; if (instr_addr !== 32'h8000_0044) begin bad++; $display("FAIL j_ignored_addr got=%h exp=80000044", instr_addr); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL j_after_valid got=%b exp=1", id_valid); end
        total++; if (id_pc_plus4 !== 32'h8000_0044) begin bad++; $display("FAIL j_after_pc4 got=%h exp=80000044", id_pc_plus4); end
        pc_src = 3'b000;
    endtask

    task automatic test_stall();
        stall = 1'b1; pc_src = 3'b011; jr_target = 32'h1234_5678;
        step(); step();
        total++; if (instr_addr !== 32'h8000_0044) begin bad++; $display("FAIL stall_addr got=%h exp=80000044", instr_addr); end
        total++; if (id_pc_plus4 !== 32'h8000_0044) begin bad++; $display("FAIL stall_pc4 got=%h exp=80000044", id_pc_plus4); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", id_valid); end
        total++; if (id_instr !== 32'h2008_0001) begin bad++; $display("FAIL stall_instr got=%h exp=20080001", id_instr); end
        branch_taken = 1'b1; branch_target = 32'h0000_0100;
        step();
        total++; if (instr_addr !== 32'h0000_0100) begin bad++; $display("FAIL br_addr got=%h exp=00000100", instr_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", id_valid); end
        total++; if (id_pc_plus4 !== 32'h0000_0100) begin bad++; $display("FAIL br_pc4 got=%h exp=00000100", id_pc_plus4); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL br_instr got=%h exp=0", id_instr); end
        stall = 1'b0; branch_taken = 1'b0; pc_src = 3'b000;
    endtask

    task automatic test_irq_user();
        int seen;
        step();                                   // PC=104, ID valid user
        pc_src = 3'b011; jr_target = 32'h0000_001C;
        step();
        total++; if (instr_addr !== 32'h0000_001C) begin bad++; $display("FAIL jr_addr got=%h exp=0000001c", instr_addr); end
        pc_src = 3'b000;
        step();
        total++; if (id_pc_plus4 !== 32'h0000_0020) begin bad++; $display("FAIL irq_setup_pc4 got=%h exp=00000020", id_pc_plus4); end
        stall = 1'b1;
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq_to_id); end
        irq_in = 1'b1;
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            irq_in = 1'b0;
            if (irq_to_id === 1'b1 && seen == 0) seen = k;
        end
        total++; if (seen != IRQ_LAT) begin bad++; $display("FAIL irq_latency got=%0d exp=%0d", seen, IRQ_LAT); end
        pc_src = 3'b100;
        step();                                   // stall blocks acceptance
        total++; if (instr_addr !== 32'h0000_0020) begin bad++; $display("FAIL irq_stall_addr got=%h exp=00000020", instr_addr); end
        total++; if (irq_to_id !== 1'b1) begin bad++; $display("FAIL irq_stall_held got=%b exp=1", irq_to_id); end
        stall = 1'b0;
        step();
        total++; if (instr_addr !== 32'h8000_0004) begin bad++; $display("FAIL irq_vec got=%h exp=80000004", instr_addr); end
        total++; if (id_pc_plus4 !== 32'h8000_0004) begin bad++; $display("FAIL irq_vec_pc4 got=%h exp=80000004", id_pc_plus4); end
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", irq_to_id); end
        pc_src = 3'b000;
    endtask

    task automatic test_kernel_irq();
        step();                                   // ID valid, pc4=80000008
        total++; if (id_pc_plus4 !== 32'h8000_0008) begin bad++; $display("FAIL k_pc4 got=%h exp=80000008", id_pc_plus4); end
        stall = 1'b1;
        irq_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            irq_in = 1'b0;
            total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL k_masked[%0d] got=%b exp=0", k, irq_to_id); end
        end
        stall = 1'b0; pc_src = 3'b110; jr_target = 32'h0000_0030;
        step();
        total++; if (instr_addr !== 32'h0000_0030) begin bad++; $display("FAIL k_jalr_addr got=%h exp=00000030", instr_addr); end
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL k_bubble_irq got=%b exp=0", irq_to_id); end
        pc_src = 3'b000;
        step();
        total++; if (id_pc_plus4 !== 32'h0000_0034) begin bad++; $display("FAIL k_user_pc4 got=%h exp=00000034", id_pc_plus4); end
        total++; if (irq_to_id !== 1'b1) begin bad++; $display("FAIL k_user_irq got=%b exp=1", irq_to_id); end
    endtask

    task automatic test_reset_mid();
        pc_src = 3'b101;
        reset = 1'b1;
        #1;
        total++; if (instr_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_mid_addr got=%h exp=80000000", instr_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", id_valid); end
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL rst_mid_irq got=%b exp=0", irq_to_id); end
        step();
        total++; if (instr_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_hold_addr got=%h exp=80000000", instr_addr); end
        reset = 1'b0;
        step();
        total++; if (instr_addr !== 32'h8000_0004) begin bad++; $display("FAIL rst_noexc_addr got=%h exp=80000004", instr_addr); end
        pc_src = 3'b011; jr_target = 32'h0000_0040;
        step();
        pc_src = 3'b000;
        step();
        total++; if (id_pc_plus4 !== 32'h0000_0044) begin bad++; $display("FAIL rst_user_pc4 got=%h exp=00000044", id_pc_plus4); end
        total++; if (irq_to_id !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", irq_to_id); end
    endtask

    task automatic test_vectors();
        pc_src = 3'b001;
        step();
        total++; if (instr_addr !== 32'h0000_0048) begin bad++; $display("FAIL br_code_addr got=%h exp=00000048", instr_addr); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL br_code_valid got=%b exp=1", id_valid); end
        pc_src = 3'b101;
        step();
        total++; if (instr_addr !== 32'h8000_0008) begin bad++; $display("FAIL exc_addr got=%h exp=80000008", instr_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL exc_valid got=%b exp=0", id_valid); end
        total++; if (id_pc_plus4 !== 32'h8000_0008) begin bad++; $display("FAIL exc_pc4 got=%h exp=80000008", id_pc_plus4); end
        pc_src = 3'b000;
        step();
        total++; if (instr_addr !== 32'h8000_000C) begin bad++; $display("FAIL exc_next got=%h exp=8000000c", instr_addr); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_irq_user();
        test_kernel_irq();
        test_reset_mid();
        test_vectors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
